// File: rtl/raster_tri_scanner_if.sv
// Triangle-in / pixel-out bundle of the raster scanner front end.
// The master side is the controller plus pixel consumer; the slave side is the scanner.
interface raster_tri_scanner_if;
  logic        vertice_ready;
  logic [11:0] vertice1_x;
  logic [11:0] vertice1_y;
  logic [11:0] vertice2_x;
  logic [11:0] vertice2_y;
  logic [11:0] vertice3_x;
  logic [11:0] vertice3_y;
  logic [20:0] vertice1_depth;
  logic [20:0] vertice2_depth;
  logic [20:0] vertice3_depth;
  logic [23:0] vertice1_color;
  logic [23:0] vertice2_color;
  logic [23:0] vertice3_color;
  logic        get_next_triangle;
  // Pixel stream: a pixel transfers on a rising edge where pixel_valid & pixel_ready;
  // while pixel_valid=1 and pixel_ready=0 every pixel_* signal holds its value.
  logic        pixel_valid;
  logic        pixel_ready;
  logic [11:0] pixel_x;
  logic [11:0] pixel_y;
  logic [20:0] pixel_depth;
  logic [23:0] pixel_color;
  logic        busy;
  logic        tri_overrun;

  modport master (
    output vertice_ready, vertice1_x, vertice1_y, vertice2_x, vertice2_y,
           vertice3_x, vertice3_y, vertice1_depth, vertice2_depth, vertice3_depth,
           vertice1_color, vertice2_color, vertice3_color, pixel_ready,
    input  get_next_triangle, pixel_valid, pixel_x, pixel_y, pixel_depth,
           pixel_color, busy, tri_overrun
  );

  modport slave (
    input  vertice_ready, vertice1_x, vertice1_y, vertice2_x, vertice2_y,
           vertice3_x, vertice3_y, vertice1_depth, vertice2_depth, vertice3_depth,
           vertice1_color, vertice2_color, vertice3_color, pixel_ready,
    output get_next_triangle, pixel_valid, pixel_x, pixel_y, pixel_depth,
           pixel_color, busy, tri_overrun
  );
endinterface

// File: rtl/raster_tri_scanner.sv
// Walks a triangle's screen-clipped bounding box in raster order, one candidate per
// cycle, and streams the covered pixels out with flat vertex-1 depth and color.
module raster_tri_scanner #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                 clk,
  input  logic                 srst,
  raster_tri_scanner_if.slave  bus,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [11:0] X_LAST = 12'(SCREEN_W - 1);
  localparam logic [11:0] Y_LAST = 12'(SCREEN_H - 1);

  function automatic logic signed [12:0] sdiff(input logic [11:0] a, input logic [11:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  // Operands are sign-extended first so the 26-bit product is formed at full width.
  function automatic logic signed [26:0] smul(input logic signed [12:0] a,
                                              input logic signed [12:0] b);
    logic signed [26:0] ae;
    logic signed [26:0] be;
    ae = 27'(a);
    be = 27'(b);
    return ae * be;
  endfunction

  function automatic logic [11:0] min3(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c);
    logic [11:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [11:0] max3(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c);
    logic [11:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  state_t r_state;
  state_t w_state_next;

  logic [11:0] r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
  logic [20:0] r_depth;
  logic [23:0] r_color;
  logic [11:0] r_xmin, r_xmax, r_ymax;
  logic [11:0] r_cx, r_cy;
  logic        r_pix_valid;
  logic [11:0] r_pix_x, r_pix_y;
  logic [20:0] r_pix_depth;
  logic [23:0] r_pix_color;
  logic        r_overrun;

  logic [11:0]        w_xmin_raw, w_xmax_raw, w_ymin_raw, w_ymax_raw;
  logic [11:0]        w_xmax, w_ymax;
  logic signed [26:0] w_area;
  logic               w_empty;
  logic signed [26:0] w_e0, w_e1, w_e2;
  logic               w_inside;
  logic               w_last;
  logic               w_slot_free;
  logic               w_emit;
  logic               w_advance;
  logic               w_clear;

  // Bounding box and signed doubled area, evaluated from the latched vertices in SETUP.
  assign w_xmin_raw = min3(r_x1, r_x2, r_x3);
  assign w_xmax_raw = max3(r_x1, r_x2, r_x3);
  assign w_ymin_raw = min3(r_y1, r_y2, r_y3);
  assign w_ymax_raw = max3(r_y1, r_y2, r_y3);
  assign w_xmax     = (w_xmax_raw > X_LAST) ? X_LAST : w_xmax_raw;
  assign w_ymax     = (w_ymax_raw > Y_LAST) ? Y_LAST : w_ymax_raw;
  assign w_area     = smul(sdiff(r_x2, r_x1), sdiff(r_y3, r_y1))
                    - smul(sdiff(r_y2, r_y1), sdiff(r_x3, r_x1));
  assign w_empty    = (w_area == '0) || (w_xmin_raw > X_LAST) || (w_ymin_raw > Y_LAST);

  assign w_e0 = smul(sdiff(r_cx, r_x1), sdiff(r_y2, r_y1)) - smul(sdiff(r_cy, r_y1), sdiff(r_x2, r_x1));
  assign w_e1 = smul(sdiff(r_cx, r_x2), sdiff(r_y3, r_y2)) - smul(sdiff(r_cy, r_y2), sdiff(r_x3, r_x2));
  assign w_e2 = smul(sdiff(r_cx, r_x3), sdiff(r_y1, r_y3)) - smul(sdiff(r_cy, r_y3), sdiff(r_x1, r_x3));

  // Either winding counts as covered; pixels on an edge are included.
  assign w_inside = (!w_e0[26] && !w_e1[26] && !w_e2[26]) ||
                    ((w_e0[26] || w_e0 == '0) && (w_e1[26] || w_e1 == '0) &&
                     (w_e2[26] || w_e2 == '0));
  assign w_last      = (r_cx == r_xmax) && (r_cy == r_ymax);
  assign w_slot_free = !r_pix_valid || bus.pixel_ready;

  always_ff @(posedge clk) begin
    if (srst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_advance    = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.vertice_ready) w_state_next = S_SETUP;
      S_SETUP: w_state_next = w_empty ? S_DONE : S_SCAN;
      S_SCAN: begin
        if (w_inside) begin
          w_emit    = w_slot_free;
          w_advance = w_slot_free;
        end else begin
          w_advance = 1'b1;
          w_clear   = w_slot_free;
        end
        if (w_advance && w_last) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_slot_free) begin
          w_clear      = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_x1 <= '0; r_y1 <= '0; r_x2 <= '0; r_y2 <= '0; r_x3 <= '0; r_y3 <= '0;
      r_depth     <= '0;
      r_color     <= '0;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_ymax      <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_depth <= '0;
      r_pix_color <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.vertice_ready) begin
        r_x1    <= bus.vertice1_x;
        r_y1    <= bus.vertice1_y;
        r_x2    <= bus.vertice2_x;
        r_y2    <= bus.vertice2_y;
        r_x3    <= bus.vertice3_x;
        r_y3    <= bus.vertice3_y;
        r_depth <= bus.vertice1_depth;
        r_color <= bus.vertice1_color;
      end
      if (r_state != S_IDLE && bus.vertice_ready) r_overrun <= 1'b1;
      if (r_state == S_SETUP) begin
        r_xmin <= w_xmin_raw;
        r_xmax <= w_xmax;
        r_ymax <= w_ymax;
        r_cx   <= w_xmin_raw;
        r_cy   <= w_ymin_raw;
      end
      if (w_advance) begin
        if (r_cx == r_xmax) begin
          r_cx <= r_xmin;
          r_cy <= r_cy + 12'd1;
        end else begin
          r_cx <= r_cx + 12'd1;
        end
      end
      if (w_emit) begin
        r_pix_valid <= 1'b1;
        r_pix_x     <= r_cx;
        r_pix_y     <= r_cy;
        r_pix_depth <= r_depth;
        r_pix_color <= r_color;
      end else if (w_clear) begin
        r_pix_valid <= 1'b0;
      end
    end
  end

  assign bus.get_next_triangle = (r_state == S_DONE);
  assign bus.busy              = (r_state != S_IDLE);
  assign bus.tri_overrun       = r_overrun;
  assign bus.pixel_valid       = r_pix_valid;
  assign bus.pixel_x           = r_pix_x;
  assign bus.pixel_y           = r_pix_y;
  assign bus.pixel_depth       = r_pix_depth;
  assign bus.pixel_color       = r_pix_color;
  assign o_dbg_state           = r_state;

endmodule
